booth_divide: RTL and testbench

Sequential signed divider that inverts the 4-bit radix-4 multiplier datapath. It takes a 2·WIDTH-bit signed dividend, such as a product from the multiplier, and a WIDTH-bit signed divisor. It returns a WIDTH-bit quotient and remainder using restoring division, one quotient bit per clock. It sits beside the multiplier in the arithmetic unit and reports completion through a start/busy/done handshake.

---
 rtl/booth_divide_pkg.sv | 17 +
 rtl/booth_divide_if.sv | 31 +++
 rtl/booth_divide_div_step.sv | 23 ++
 rtl/booth_divide.sv | 140 ++++++++++++++
 tb/tb_booth_divide.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/booth_divide_pkg.sv
// Shared arithmetic definitions for the multiply/divide unit.
// Holds the divider state encoding and common width constants.
package booth_divide_pkg;

    localparam int WIDTH_DEF = 4;

    // Wide enough to slice for any operand width in use.
    localparam logic [63:0] DBZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/booth_divide_if.sv
// Request/response bundle for the sequential signed divider.
// The master drives operands and start; the slave returns results.
interface booth_divide_if
    import booth_divide_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder,
        input  div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder,
        output div_by_zero, overflow
    );

endinterface

// File: rtl/booth_divide_div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, restore on borrow.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, dvsr_i};
        q_o     = ~diff[WIDTH+1];
        rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/booth_divide.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Sign handling and result formatting happen in a single FIX cycle.
module booth_divide
    import booth_divide_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic          clk,
    input logic          rst,
    booth_divide_if.slave bus
);

    localparam int CW = $clog2(2 * WIDTH);

    div_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  dvd_q, dvd_d;
    logic [2*WIDTH-1:0]  qmag_q, qmag_d;
    logic [WIDTH-1:0]    dvsr_q, dvsr_d;
    logic [WIDTH:0]      rem_q, rem_d;
    logic                sd_q, sd_d;
    logic                sv_q, sv_d;
    logic                zero_q, zero_d;
    logic [WIDTH-1:0]    quot_q, quot_d;
    logic [WIDTH-1:0]    remo_q, remo_d;
    logic                dbz_q, dbz_d;
    logic                ovf_q, ovf_d;

    logic [WIDTH:0]      step_rem;
    logic                step_q;
    logic [2*WIDTH-1:0]  qs;
    logic [WIDTH-1:0]    rs;
    logic [WIDTH:0]      qs_top;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[2*WIDTH-1]),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            qmag_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            qmag_q  <= qmag_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        qmag_d  = qmag_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        qs      = sd_q ^ sv_q ? -qmag_q : qmag_q;
        rs      = sd_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        qs_top  = qs[2*WIDTH-1:WIDTH-1];

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sd_d   = bus.dividend[2*WIDTH-1];
                    sv_d   = bus.divisor[WIDTH-1];
                    dvd_d  = sd_d ? -bus.dividend : bus.dividend;
                    dvsr_d = sv_d ? -bus.divisor : bus.divisor;
                    zero_d = (bus.divisor == '0);
                    rem_d  = '0;
                    qmag_d = '0;
                    cnt_d  = CW'(2 * WIDTH - 1);
                    state_d = zero_d ? FIX : CALC;
                end
            end
            CALC: begin
                dvd_d  = dvd_q << 1;
                rem_d  = step_rem;
                qmag_d = {qmag_q[2*WIDTH-2:0], step_q};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                if (zero_q) begin
                    quot_d = DBZ_QUOT[WIDTH-1:0];
                    remo_d = '0;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    quot_d = qs[WIDTH-1:0];
                    remo_d = rs;
                    dbz_d  = 1'b0;
                    // Fits only if the upper bits sign-extend bit WIDTH-1.
                    ovf_d  = !((&qs_top) || (~|qs_top));
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divide.sv
// Scoreboard bench for booth_divide: integer reference model,
// latency, handshake, ignored-start and mid-operation reset checks.
module tb_booth_divide;
    import booth_divide_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    booth_divide_if #(.WIDTH(W)) bus ();

    booth_divide #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        int sa;
        int sb_;
        int tq;
        int tr;
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        if (sb_ == 0) begin
            e.q   = '1;
            e.r   = '0;
            e.dbz = 1'b1;
            e.ovf = 1'b0;
            e.lat = 1;
        end else begin
            tq    = sa / sb_;
            tr    = sa % sb_;
            e.q   = tq[W-1:0];
            e.r   = tr[W-1:0];
            e.dbz = 1'b0;
            e.ovf = (tq > 7) || (tq < -8);
            e.lat = 2 * W + 1;
        end
        return e;
    endfunction

    task automatic start_op(input logic [2*W-1:0] a,
                            input logic [W-1:0] b,
                            input bit track);
        int n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) check_eq("idle_timeout", 1, 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        if (track) begin
            check_eq("accepted", 32'(bus.busy), 1);
            sb.push_back(model(a, b));
        end
    endtask

    task automatic wait_done();
        int n = 0;
        exp_t e;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else if (!bus.done) begin
            check_eq("done_timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check_eq("quotient", 32'(bus.quotient), 32'(e.q));
            check_eq("remainder", 32'(bus.remainder), 32'(e.r));
            check_eq("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
            check_eq("overflow", 32'(bus.overflow), 32'(e.ovf));
            check_eq("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            @(posedge clk); #1;
            check_eq("done_pulse", 32'(bus.done), 0);
            check_eq("busy_fall", 32'(bus.busy), 0);
            check_eq("q_hold", 32'(bus.quotient), 32'(e.q));
        end
    endtask

    task automatic run_op(input logic [2*W-1:0] a,
                          input logic [W-1:0] b);
        start_op(a, b, 1'b1);
        wait_done();
    endtask

    initial begin
        int dcnt;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_q", 32'(bus.quotient), 0);
        check_eq("rst_r", 32'(bus.remainder), 0);
        check_eq("rst_dbz", 32'(bus.div_by_zero), 0);
        check_eq("rst_ovf", 32'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h2D, 4'h7);
        run_op(8'hD3, 4'h7);
        run_op(8'h2D, 4'h9);
        run_op(8'h80, 4'hF);
        run_op(8'h64, 4'h7);
        run_op(8'h17, 4'h0);
        run_op(8'hD3, 4'h9);
        run_op(8'h7F, 4'h8);
        run_op(8'h80, 4'h1);
        run_op(8'h00, 4'h3);
        run_op(8'h05, 4'h8);

        // Second start arrives mid-calculation and must be dropped.
        start_op(8'h2D, 4'h7, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'h64;
        bus.divisor  = 4'h3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // Abort mid-calculation; no done pulse may follow.
        start_op(8'hD3, 4'h9, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy", 32'(bus.busy), 0);
        check_eq("abort_done", 32'(bus.done), 0);
        check_eq("abort_q", 32'(bus.quotient), 0);
        check_eq("abort_r", 32'(bus.remainder), 0);
        check_eq("abort_dbz", 32'(bus.div_by_zero), 0);
        check_eq("abort_ovf", 32'(bus.overflow), 0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done) dcnt++;
        end
        check_eq("no_done_after_rst", 32'(dcnt), 0);
        run_op(8'h2D, 4'h7);

        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
